ui_screen_mux: RTL
==================

# ui_screen_mux

Parametrised full-screen UI renderer that replaces the fixed four-screen, one-palette menu display. It drives the address bus for NUM_SCREENS external 2-bit-per-pixel image ROMs and turns the selected screen's pixel into 12-bit RGB through a per-screen writable palette. UI screen changes are latched only at frame boundaries and are revealed with a left-to-right wipe. It sits between the top-level UI state machine and the VGA pixel mux.

## Interface
- WIDTH, 512: image width in pixels.
- HEIGHT, 384: image height in pixels.
- NUM_SCREENS, 4: number of screen ROMs (2..8).
- ADDR_W, 18: ROM address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- ROM_LATENCY, 2: ROM read latency in cycles (1..3).
- WIPE_STEP, 16: columns revealed per frame during a transition.

- clk_in  in  1  pixel clock.
- reset_in  in  1  asynchronous, active-high reset.
- state  in  4  UI state; the value is the requested screen index.
- hcount  in  13  current pixel column.
- vcount  in  13  current pixel row.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- pal_we  in  1  palette write strobe.
- pal_screen  in  3  palette write: screen index.
- pal_index  in  2  palette write: colour index.
- pal_data  in  12  palette write: RGB value {R,G,B}.
- rom_addr  out  ADDR_W  address shared by all screen ROMs.
- rom_data  in  2*NUM_SCREENS  ROM outputs; screen s occupies bits [2s+1:2s].
- pixel_out  out  12  RGB pixel.
- busy  out  1  high while a wipe is in progress.

## Operation
- Requested screen:
  - req = state when state < NUM_SCREENS.
  - req = 0 otherwise.
- Screen registers: cur_scr (the screen being shown), old_scr (the screen being replaced) and wipe_col (11 bits).
- All three registers change only on a cycle with frame_start = 1:
  - If req != cur_scr: old_scr <= cur_scr, cur_scr <= req, wipe_col <= 0, busy <= 1.
  - Else if busy: wipe_col <= wipe_col + WIPE_STEP. If that sum is >= WIDTH, wipe_col <= WIDTH and busy <= 0.
- A new request arriving mid-wipe restarts the wipe. The screen shown on the old side becomes the previous cur_scr.
- Screen selection per pixel, with x being the delayed column:
  - x < wipe_col uses cur_scr.
  - Otherwise uses old_scr.
  - When busy = 0, cur_scr is always used.
- Address: rom_addr = hcount + vcount*WIDTH, truncated to ADDR_W. The product is computed at full width before truncation.
- Palette: storage is NUM_SCREENS x 4 x 12 bits.
  - A write with pal_we = 1 is visible from the following cycle.
  - A write with pal_screen >= NUM_SCREENS is ignored.
  - A pixel read of the entry being written in the same cycle returns the old value.
- Window: if the delayed hcount >= WIDTH or the delayed vcount >= HEIGHT, pixel_out = 0.

## Timing
- Reset values:
  - rom_addr = 0, pixel_out = 0, busy = 0.
  - cur_scr = old_scr = 0, wipe_col = WIDTH.
  - All delay-line stages = 0.
  - Palette for every screen: idx0 = 000, idx1 = F00, idx2 = 00F, idx3 = 0F0.
- Pipeline:
  - Cycle 0: hcount/vcount presented.
  - Cycle 1: rom_addr registered.
  - Cycles 1..1+ROM_LATENCY: ROM access.
  - The palette lookup is registered into pixel_out.
  - Total latency from hcount/vcount to pixel_out is ROM_LATENCY+2 cycles.
  - The column value and in-window flag are delayed by the same amount.
- cur_scr/old_scr/wipe_col are sampled for each pixel at the palette-lookup stage. A frame_start update therefore takes effect on the pixel at pipeline stage ROM_LATENCY+1.
- Reset asserted mid-frame clears everything within the same cycle, because the reset is asynchronous. Output resumes ROM_LATENCY+2 cycles after release.

## Structure
- Package ui_pkg holds:
  - the colour type rgb12_t;
  - default palette constants PAL_DEF0..PAL_DEF3;
  - the screen index constants SCR_IDLE=0, SCR_MANUAL=1, SCR_SOLVE=2, SCR_GEN=3.
- Sub-module ui_palette_ram: register-array palette with one write port and one registered read port, reset to the defaults.
- The ROMs stay outside the block and are instantiated by the parent.

## Test plan
- Reset, state=0, ROM model returns idx1 at address 0, hcount=vcount=0: pixel_out=F00 exactly ROM_LATENCY+2 cycles later; rom_addr=0.
- hcount=520, vcount=10: pixel_out=000 after the pipeline delay. Separately, hcount=5, vcount=3 -> rom_addr=1541.
- state=7: the bench checks cur_scr stays 0 and busy stays 0 across 3 frames.
- state 0->2 before frame_start: on frame_start busy=1, wipe_col=0.
  - After 1 frame (wipe_col=16): column 15 shows screen 2 and column 16 shows screen 0.
  - After 32 frames busy=0.
- Mid-wipe, state 2->3: the next frame_start sets old_scr=2, cur_scr=3, wipe_col=0.
- pal_we with screen 1, idx 2, data ABC:
  - Screen 1 pixels of idx 2 read ABC from the next cycle.
  - Screen 0 pixels of idx 2 are still 00F.
  - A write with pal_screen=5 (>= NUM_SCREENS) is ignored.

Source files
------------

// File: rtl/ui_pkg.sv
// Shared types and constants for the UI screen renderer.
package ui_pkg;

  typedef logic [11:0] rgb12_t;

  // Power-on palette, identical for every screen.
  localparam rgb12_t PAL_DEF0 = 12'h000;
  localparam rgb12_t PAL_DEF1 = 12'hF00;
  localparam rgb12_t PAL_DEF2 = 12'h00F;
  localparam rgb12_t PAL_DEF3 = 12'h0F0;

  // Screen indices as driven by the top-level UI state machine.
  localparam logic [2:0] SCR_IDLE   = 3'd0;
  localparam logic [2:0] SCR_MANUAL = 3'd1;
  localparam logic [2:0] SCR_SOLVE  = 3'd2;
  localparam logic [2:0] SCR_GEN    = 3'd3;

  // Default palette entry for a colour index.
  function automatic rgb12_t pal_default(input logic [1:0] idx);
    case (idx)
      2'd0:    return PAL_DEF0;
      2'd1:    return PAL_DEF1;
      2'd2:    return PAL_DEF2;
      default: return PAL_DEF3;
    endcase
  endfunction

endpackage

// File: rtl/ui_palette_ram.sv
// Per-screen 4-entry palette: one write port, one registered read port.
module ui_palette_ram
  import ui_pkg::*;
#(
  parameter int NUM_SCREENS = 4
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       wr_en,
  input  logic [2:0] wr_scr,
  input  logic [1:0] wr_idx,
  input  rgb12_t     wr_data,
  input  logic [2:0] rd_scr,
  input  logic [1:0] rd_idx,
  input  logic       rd_clear,
  output rgb12_t     rd_data
);

  rgb12_t mem [NUM_SCREENS][4];
  rgb12_t rd_word;

  // Write port; a screen index outside the array never matches and is dropped.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      // NOTE: the palette must come up with defaults, so it is built from resettable flops rather than a RAM macro.
      for (int s = 0; s < NUM_SCREENS; s++) begin
        for (int i = 0; i < 4; i++) begin
          mem[s][i] <= pal_default(2'(i));
        end
      end
    end else if (wr_en) begin
      for (int s = 0; s < NUM_SCREENS; s++) begin
        for (int i = 0; i < 4; i++) begin
          // NOTE: non-blocking here so the read port in the same edge still sees the old entry.
          if (wr_scr == 3'(s) && wr_idx == 2'(i)) mem[s][i] <= wr_data;
        end
      end
    end
  end

  // Read multiplexer over the current array contents.
  always_comb begin
    // NOTE: default first so no path leaves rd_word unassigned (no latch).
    rd_word = '0;
    for (int s = 0; s < NUM_SCREENS; s++) begin
      for (int i = 0; i < 4; i++) begin
        if (rd_scr == 3'(s) && rd_idx == 2'(i)) rd_word = mem[s][i];
      end
    end
  end

  // Registered read; rd_clear blanks pixels outside the image window.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) rd_data <= '0;
    else          rd_data <= rd_clear ? '0 : rd_word;
  end

endmodule

// File: rtl/ui_screen_mux.sv
// Full-screen UI renderer: ROM addressing, frame-latched screen switching
// with a left-to-right wipe, and per-screen palette lookup.
module ui_screen_mux
  import ui_pkg::*;
#(
  parameter int WIDTH       = 512,
  parameter int HEIGHT      = 384,
  parameter int NUM_SCREENS = 4,
  parameter int ADDR_W      = 18,
  parameter int ROM_LATENCY = 2,
  parameter int WIPE_STEP   = 16
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [3:0]               state,
  input  logic [12:0]              hcount,
  input  logic [12:0]              vcount,
  input  logic                     frame_start,
  input  logic                     pal_we,
  input  logic [2:0]               pal_screen,
  input  logic [1:0]               pal_index,
  input  logic [11:0]              pal_data,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [2*NUM_SCREENS-1:0] rom_data,
  output logic [11:0]              pixel_out,
  output logic                     busy
);

  localparam logic [12:0] WIDTH_C   = 13'(WIDTH);
  localparam logic [12:0] HEIGHT_C  = 13'(HEIGHT);
  localparam logic [10:0] WIPE_END  = 11'(WIDTH);
  localparam logic [11:0] WIPE_LIM  = 12'(WIDTH);
  localparam logic [11:0] WIPE_INC  = 12'(WIPE_STEP);
  localparam logic [3:0]  NUM_SCR_C = 4'(NUM_SCREENS);

  logic [2:0]  req_scr;
  logic [2:0]  cur_scr;
  logic [2:0]  old_scr;
  logic [2:0]  sel_scr;
  logic [10:0] wipe_col;
  logic [11:0] wipe_sum;
  logic [31:0] addr_full;
  logic [1:0]  pix_idx;

  // Column and in-window flag travel alongside the ROM access; stage
  // ROM_LATENCY lines up with rom_data.
  logic [12:0]          col_pipe [ROM_LATENCY+1];
  logic [ROM_LATENCY:0] win_pipe;

  // Out-of-range UI states fall back to the idle screen.
  always_comb begin
    req_scr = SCR_IDLE;
    if (state < NUM_SCR_C) req_scr = state[2:0];
  end

  assign wipe_sum  = {1'b0, wipe_col} + WIPE_INC;
  assign addr_full = 32'(hcount) + 32'(vcount) * 32'(WIDTH);

  // Screen switch and wipe progress, updated only at frame boundaries.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cur_scr  <= SCR_IDLE;
      old_scr  <= SCR_IDLE;
      wipe_col <= WIPE_END;
      busy     <= 1'b0;
    end else if (frame_start) begin
      if (req_scr != cur_scr) begin
        old_scr  <= cur_scr;
        cur_scr  <= req_scr;
        wipe_col <= '0;
        busy     <= 1'b1;
      end else if (busy) begin
        if (wipe_sum >= WIPE_LIM) begin
          wipe_col <= WIPE_END;
          busy     <= 1'b0;
        end else begin
          wipe_col <= wipe_sum[10:0];
        end
      end
    end
  end

  // ROM address register and column/window delay line.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      rom_addr <= '0;
      win_pipe <= '0;
      for (int k = 0; k <= ROM_LATENCY; k++) col_pipe[k] <= '0;
    end else begin
      rom_addr    <= addr_full[ADDR_W-1:0];
      col_pipe[0] <= hcount;
      win_pipe[0] <= (hcount < WIDTH_C) && (vcount < HEIGHT_C);
      for (int k = 1; k <= ROM_LATENCY; k++) begin
        col_pipe[k] <= col_pipe[k-1];
        win_pipe[k] <= win_pipe[k-1];
      end
    end
  end

  // Pick the screen for this pixel (wipe boundary) and extract its 2-bit index.
  always_comb begin
    sel_scr = cur_scr;
    if (busy && ({2'b00, wipe_col} <= col_pipe[ROM_LATENCY])) sel_scr = old_scr;
    pix_idx = '0;
    for (int s = 0; s < NUM_SCREENS; s++) begin
      if (sel_scr == 3'(s)) pix_idx = rom_data[2*s +: 2];
    end
  end

  ui_palette_ram #(
    .NUM_SCREENS (NUM_SCREENS)
  ) u_palette (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .wr_en    (pal_we),
    .wr_scr   (pal_screen),
    .wr_idx   (pal_index),
    .wr_data  (pal_data),
    .rd_scr   (sel_scr),
    .rd_idx   (pix_idx),
    .rd_clear (!win_pipe[ROM_LATENCY]),
    .rd_data  (pixel_out)
  );

endmodule
